// File: rtl/fb_port_arbiter.sv
// Shares the single-port frame-buffer BRAM between display fetch, camera writes (via FIFO) and processing reads.
// Latency: display data 2 cycles after disp_req, rd_valid 1 cycle after rd_gnt, FIFO write >=1 cycle after push.
// Backpressure: display never stalls; camera held off by wr_ready when FIFO full; processing read held until rd_gnt.
module fb_port_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic              clk_25mhz,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [FIFO_AW:0]  fifo_level
);

    typedef enum logic [1:0] {SEL_NONE, SEL_DISP, SEL_WR, SEL_RD} sel_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    localparam int LVL_W = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    wr_ent_t            fifo_mem [FIFO_DEPTH];
    wr_ent_t            push_ent;
    wr_ent_t            head;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               rd_pend;
    logic               disp_tag;
    sel_t               sel;
    sel_t               last_sel;

    assign wr_ready   = (fifo_level < FULL_LVL);
    assign push       = wr_valid & wr_ready;
    assign pop        = (sel == SEL_WR);
    assign fifo_empty = (fifo_level == '0);
    assign push_ent   = '{addr: wr_addr, data: wr_data};
    assign head       = fifo_mem[rd_ptr];
    // A request that was just granted is still high this cycle; ignore it so it is not issued twice.
    assign rd_pend    = rd_req & ~rd_gnt;

    always_comb begin
        sel = SEL_NONE;
        if (disp_req) begin
            sel = SEL_DISP;
        end else if (!fifo_empty && rd_pend) begin
            sel = (last_sel == SEL_WR) ? SEL_RD : SEL_WR;
        end else if (!fifo_empty) begin
            sel = SEL_WR;
        end else if (rd_pend) begin
            sel = SEL_RD;
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Entry storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_25mhz) begin
        if (push) fifo_mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_gnt     <= 1'b0;
            disp_tag   <= 1'b0;
            disp_valid <= 1'b0;
            rd_valid   <= 1'b0;
            last_sel   <= SEL_RD;
        end else begin
            mem_en     <= (sel != SEL_NONE);
            mem_we     <= (sel == SEL_WR);
            rd_gnt     <= (sel == SEL_RD);
            disp_tag   <= (sel == SEL_DISP);
            disp_valid <= disp_tag;
            rd_valid   <= rd_gnt;
            case (sel)
                SEL_DISP: mem_addr <= disp_addr;
                SEL_WR: begin
                    mem_addr  <= head.addr;
                    mem_wdata <= head.data;
                end
                SEL_RD:   mem_addr <= rd_addr;
                default: ;
            endcase
            if (sel == SEL_WR || sel == SEL_RD) last_sel <= sel;
        end
    end

    assign disp_data = disp_valid ? mem_rdata : '0;
    assign rd_data   = rd_valid   ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios plus a randomized run against a queue-based arbitration model.
module tb_fb_port_arbiter;

    localparam int K_NONE = 0;
    localparam int K_DISP = 1;
    localparam int K_WR   = 2;
    localparam int K_RD   = 3;

    logic        clk_25mhz;
    logic        rst_n;
    logic        disp_req;
    logic [16:0] disp_addr;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [3:0]  fifo_level;

    int n_vec = 0;
    int n_err = 0;

    fb_port_arbiter dut (
        .clk_25mhz (clk_25mhz),
        .rst_n     (rst_n),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_valid(disp_valid),
        .disp_data (disp_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .fifo_level(fifo_level)
    );

    initial clk_25mhz = 1'b0;
    always #20 clk_25mhz = ~clk_25mhz;

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // Behavioural BRAM: 256 words, registered read, untouched words read back init_val.
    logic [7:0] env_mem [256];
    bit         env_wr  [256];
    always @(posedge clk_25mhz) begin
        if (mem_en) begin
            if (mem_we) begin
                env_mem[mem_addr[7:0]] <= mem_wdata;
                env_wr[mem_addr[7:0]]  <= 1'b1;
            end else begin
                mem_rdata <= env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_val(int'(mem_addr[7:0]));
            end
        end
    end

    // Reference model: FIFO as a queue, memory as an array, one decision per clock.
    typedef struct packed {
        logic [16:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t        m_q[$];
    logic [7:0]  mmem [256];
    logic [7:0]  m_rdata;
    int          m_last;
    int          e_kind;
    logic        e_en, e_we, e_gnt, e_dv, e_rv;
    logic [16:0] e_addr;
    logic [7:0]  e_wdata, e_dd, e_rd;

    task automatic model_reset();
        m_q.delete();
        m_last  = K_RD;
        e_kind  = K_NONE;
        e_en    = 1'b0;
        e_we    = 1'b0;
        e_gnt   = 1'b0;
        e_dv    = 1'b0;
        e_rv    = 1'b0;
        e_addr  = '0;
        e_wdata = '0;
        e_dd    = '0;
        e_rd    = '0;
    endtask

    task automatic model_step();
        int  kind;
        bit  has_wr;
        bit  rd_wait;
        bit  push_ok;
        if (e_en && e_we)  mmem[e_addr[7:0]] = e_wdata;
        if (e_en && !e_we) m_rdata = mmem[e_addr[7:0]];
        e_dv = (e_kind == K_DISP);
        e_rv = (e_kind == K_RD);
        e_dd = e_dv ? m_rdata : 8'h00;
        e_rd = e_rv ? m_rdata : 8'h00;
        has_wr  = (m_q.size() > 0);
        rd_wait = rd_req && !e_gnt;
        push_ok = wr_valid && (m_q.size() < 8);
        if (disp_req)                kind = K_DISP;
        else if (has_wr && rd_wait)  kind = (m_last == K_WR) ? K_RD : K_WR;
        else if (has_wr)             kind = K_WR;
        else if (rd_wait)            kind = K_RD;
        else                         kind = K_NONE;
        e_en  = (kind != K_NONE);
        e_we  = (kind == K_WR);
        e_gnt = (kind == K_RD);
        if (kind == K_DISP) e_addr = disp_addr;
        if (kind == K_RD)   e_addr = rd_addr;
        if (kind == K_WR) begin
            e_addr  = m_q[0].a;
            e_wdata = m_q[0].d;
            void'(m_q.pop_front());
        end
        if (kind == K_WR || kind == K_RD) m_last = kind;
        if (push_ok) m_q.push_back({wr_addr, wr_data});
        e_kind = kind;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_25mhz);
        @(negedge clk_25mhz);
    endtask

    task automatic idle_inputs();
        disp_req  = 1'b0;
        disp_addr = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_req    = 1'b0;
        rd_addr   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (mem_en !== 1'b0)     begin n_err++; $display("FAIL reset_mem_en: observed %b expected 0", mem_en); end
        n_vec++; if (mem_we !== 1'b0)     begin n_err++; $display("FAIL reset_mem_we: observed %b expected 0", mem_we); end
        n_vec++; if (rd_gnt !== 1'b0)     begin n_err++; $display("FAIL reset_rd_gnt: observed %b expected 0", rd_gnt); end
        n_vec++; if (rd_valid !== 1'b0)   begin n_err++; $display("FAIL reset_rd_valid: observed %b expected 0", rd_valid); end
        n_vec++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL reset_disp_valid: observed %b expected 0", disp_valid); end
        n_vec++; if (mem_addr !== 17'h0)  begin n_err++; $display("FAIL reset_mem_addr: observed %0h expected 0", mem_addr); end
        n_vec++; if (mem_wdata !== 8'h0)  begin n_err++; $display("FAIL reset_mem_wdata: observed %0h expected 0", mem_wdata); end
        n_vec++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL reset_level: observed %0d expected 0", fifo_level); end
        n_vec++; if (wr_ready !== 1'b1)   begin n_err++; $display("FAIL reset_wr_ready: observed %b expected 1", wr_ready); end
    endtask

    task automatic test_write_order();
        int k = 0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = (i < 4);
            wr_addr  = 17'(i);
            wr_data  = 8'hA0 + 8'(i);
            cycle();
            n_vec++;
            if (fifo_level !== 4'(m_q.size())) begin
                n_err++; $display("FAIL wo_level i=%0d: observed %0d expected %0d", i, fifo_level, m_q.size());
            end
            if (mem_we === 1'b1) begin
                n_vec++;
                if (k >= 4 || mem_addr !== 17'(k) || mem_wdata !== 8'hA0 + 8'(k)) begin
                    n_err++; $display("FAIL wo_write k=%0d: observed %0h/%0h expected %0h/%0h", k, mem_addr, mem_wdata, k, 8'hA0 + 8'(k));
                end
                k++;
            end
        end
        n_vec++; if (k !== 4) begin n_err++; $display("FAIL wo_count: observed %0d expected 4", k); end
        n_vec++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL wo_final_level: observed %0d expected 0", fifo_level); end
    endtask

    task automatic test_disp_burst();
        logic exp_dv, exp_we;
        for (int j = 0; j < 15; j++) begin
            disp_req  = (j < 10);
            disp_addr = 17'($urandom_range(0, 255));
            wr_valid  = (j < 3);
            wr_addr   = 17'(16 + j);
            wr_data   = 8'hB0 + 8'(j);
            cycle();
            exp_dv = (j >= 1 && j <= 10);
            exp_we = (j >= 10 && j <= 12);
            n_vec++; if (disp_valid !== exp_dv) begin n_err++; $display("FAIL db_disp_valid j=%0d: observed %b expected %b", j, disp_valid, exp_dv); end
            n_vec++; if (mem_we !== exp_we)     begin n_err++; $display("FAIL db_mem_we j=%0d: observed %b expected %b", j, mem_we, exp_we); end
            n_vec++; if (disp_data !== e_dd)    begin n_err++; $display("FAIL db_disp_data j=%0d: observed %0h expected %0h", j, disp_data, e_dd); end
        end
    endtask

    task automatic test_round_robin();
        int  obs, prev, nwr, nrd, ngnt;
        logic prev_gnt;
        for (int i = 0; i < 4; i++) begin
            disp_req  = 1'b1;
            disp_addr = 17'($urandom_range(0, 255));
            wr_valid  = 1'b1;
            wr_addr   = 17'(32 + i);
            wr_data   = 8'hC0 + 8'(i);
            cycle();
        end
        disp_req = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        rd_addr  = 17'($urandom_range(0, 255));
        prev = -1; nwr = 0; nrd = 0; ngnt = 0; prev_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            obs = !mem_en ? K_NONE : mem_we ? K_WR : rd_gnt ? K_RD : K_DISP;
            n_vec++; if (obs != K_WR && obs != K_RD) begin n_err++; $display("FAIL rr_kind i=%0d: observed %0d expected WR or RD", i, obs); end
            n_vec++; if (obs == prev) begin n_err++; $display("FAIL rr_alternate i=%0d: observed %0d expected not %0d", i, obs, prev); end
            n_vec++; if (rd_valid !== prev_gnt) begin n_err++; $display("FAIL rr_rd_valid i=%0d: observed %b expected %b", i, rd_valid, prev_gnt); end
            n_vec++; if (rd_data !== e_rd) begin n_err++; $display("FAIL rr_rd_data i=%0d: observed %0h expected %0h", i, rd_data, e_rd); end
            if (obs == K_WR) nwr++;
            if (obs == K_RD) nrd++;
            prev = obs;
            prev_gnt = rd_gnt;
            if (rd_gnt === 1'b1) begin
                ngnt++;
                rd_addr = 17'($urandom_range(0, 255));
                if (ngnt >= 4) rd_req = 1'b0;
            end
        end
        n_vec++; if (nwr != 4 || nrd != 4) begin n_err++; $display("FAIL rr_counts: observed wr=%0d rd=%0d expected 4/4", nwr, nrd); end
    endtask

    task automatic test_backpressure();
        int  idx = 0;
        int  k = 0;
        bit  acc;
        for (int c = 0; c < 12; c++) begin
            disp_req  = 1'b1;
            disp_addr = 17'($urandom_range(0, 255));
            wr_valid  = (idx < 9);
            wr_addr   = 17'(64 + idx);
            wr_data   = 8'hD0 + 8'(idx);
            acc = wr_valid && wr_ready;
            cycle();
            if (acc) idx++;
        end
        n_vec++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL bp_level_full: observed %0d expected 8", fifo_level); end
        n_vec++; if (wr_ready !== 1'b0)   begin n_err++; $display("FAIL bp_wr_ready_full: observed %b expected 0", wr_ready); end
        n_vec++; if (idx != 8)            begin n_err++; $display("FAIL bp_accepted: observed %0d expected 8", idx); end
        disp_req = 1'b0;
        for (int c = 0; c < 30 && k < 9; c++) begin
            wr_valid = (idx < 9);
            wr_addr  = 17'(64 + idx);
            wr_data  = 8'hD0 + 8'(idx);
            acc = wr_valid && wr_ready;
            cycle();
            if (acc) idx++;
            if (mem_we === 1'b1) begin
                n_vec++;
                if (mem_addr !== 17'(64 + k) || mem_wdata !== 8'hD0 + 8'(k)) begin
                    n_err++; $display("FAIL bp_write k=%0d: observed %0h/%0h expected %0h/%0h", k, mem_addr, mem_wdata, 64 + k, 8'hD0 + 8'(k));
                end
                k++;
            end
        end
        wr_valid = 1'b0;
        n_vec++; if (k != 9)              begin n_err++; $display("FAIL bp_drain_count: observed %0d expected 9", k); end
        n_vec++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL bp_drain_level: observed %0d expected 0", fifo_level); end
    endtask

    task automatic test_push_pop();
        int  np = 0;
        int  nw = 0;
        bit  acc;
        for (int i = 0; i < 7; i++) begin
            wr_valid = (i < 6);
            wr_addr  = 17'(96 + np);
            wr_data  = 8'h40 + 8'(np);
            acc = wr_valid && wr_ready;
            cycle();
            if (acc) np++;
            if (i < 6) begin
                n_vec++; if (fifo_level !== 4'd1) begin n_err++; $display("FAIL pp_level1 i=%0d: observed %0d expected 1", i, fifo_level); end
            end
            if (mem_we === 1'b1) begin
                n_vec++;
                if (mem_addr !== 17'(96 + nw) || mem_wdata !== 8'h40 + 8'(nw)) begin
                    n_err++; $display("FAIL pp_write1 n=%0d: observed %0h/%0h expected %0h/%0h", nw, mem_addr, mem_wdata, 96 + nw, 8'h40 + 8'(nw));
                end
                nw++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            disp_req  = 1'b1;
            disp_addr = 17'($urandom_range(0, 255));
            wr_valid  = 1'b1;
            wr_addr   = 17'(96 + np);
            wr_data   = 8'h40 + 8'(np);
            acc = wr_valid && wr_ready;
            cycle();
            if (acc) np++;
        end
        disp_req = 1'b0;
        for (int i = 0; i < 16 && (i < 5 || fifo_level !== 4'd0); i++) begin
            wr_valid = (i < 5);
            wr_addr  = 17'(96 + np);
            wr_data  = 8'h40 + 8'(np);
            acc = wr_valid && wr_ready;
            cycle();
            if (acc) np++;
            if (i < 5) begin
                n_vec++; if (fifo_level !== 4'd7) begin n_err++; $display("FAIL pp_level_full i=%0d: observed %0d expected 7", i, fifo_level); end
            end
            if (mem_we === 1'b1) begin
                n_vec++;
                if (mem_addr !== 17'(96 + nw) || mem_wdata !== 8'h40 + 8'(nw)) begin
                    n_err++; $display("FAIL pp_write8 n=%0d: observed %0h/%0h expected %0h/%0h", nw, mem_addr, mem_wdata, 96 + nw, 8'h40 + 8'(nw));
                end
                nw++;
            end
        end
        wr_valid = 1'b0;
        n_vec++; if (nw != np || np != 18) begin n_err++; $display("FAIL pp_totals: observed pushes=%0d writes=%0d expected 18/18", np, nw); end
    endtask

    task automatic test_reset_midflight();
        for (int s = 0; s < 2; s++) begin
            disp_req  = (s == 0);
            disp_addr = 17'd5;
            wr_valid  = (s == 0);
            wr_addr   = 17'd120;
            wr_data   = 8'h5A;
            rd_req    = (s == 1);
            rd_addr   = 17'd7;
            cycle();
            n_vec++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL mr_issue s=%0d: observed %b expected 1", s, mem_en); end
            rst_n = 1'b0;
            idle_inputs();
            model_reset();
            #1;
            n_vec++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL mr_level s=%0d: observed %0d expected 0", s, fifo_level); end
            n_vec++; if (wr_ready !== 1'b1)   begin n_err++; $display("FAIL mr_wr_ready s=%0d: observed %b expected 1", s, wr_ready); end
            n_vec++; if (mem_en !== 1'b0)     begin n_err++; $display("FAIL mr_mem_en s=%0d: observed %b expected 0", s, mem_en); end
            @(posedge clk_25mhz);
            @(negedge clk_25mhz);
            rst_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                cycle();
                n_vec++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL mr_disp_valid s=%0d c=%0d: observed %b expected 0", s, c, disp_valid); end
                n_vec++; if (rd_valid !== 1'b0)   begin n_err++; $display("FAIL mr_rd_valid s=%0d c=%0d: observed %b expected 0", s, c, rd_valid); end
                n_vec++; if (mem_we !== 1'b0)     begin n_err++; $display("FAIL mr_mem_we s=%0d c=%0d: observed %b expected 0", s, c, mem_we); end
            end
        end
    endtask

    task automatic test_random();
        bit acc;
        for (int c = 0; c < 2000; c++) begin
            acc = wr_valid && (m_q.size() < 8);
            disp_req  = ((c % 300) < 60) || ($urandom_range(0, 99) < 30);
            disp_addr = 17'($urandom_range(0, 255));
            if (!wr_valid || acc) begin
                wr_valid = ($urandom_range(0, 1) == 1);
                wr_addr  = 17'($urandom_range(0, 255));
                wr_data  = 8'($urandom_range(0, 255));
            end
            if (rd_req && e_gnt) begin
                rd_req  = ($urandom_range(0, 1) == 1);
                rd_addr = 17'($urandom_range(0, 255));
            end else if (!rd_req) begin
                rd_req  = ($urandom_range(0, 99) < 30);
                rd_addr = 17'($urandom_range(0, 255));
            end
            cycle();
            n_vec++; if (mem_en !== e_en)       begin n_err++; $display("FAIL rnd_mem_en c=%0d: observed %b expected %b", c, mem_en, e_en); end
            n_vec++; if (mem_we !== e_we)       begin n_err++; $display("FAIL rnd_mem_we c=%0d: observed %b expected %b", c, mem_we, e_we); end
            n_vec++; if (mem_addr !== e_addr)   begin n_err++; $display("FAIL rnd_mem_addr c=%0d: observed %0h expected %0h", c, mem_addr, e_addr); end
            n_vec++; if (mem_wdata !== e_wdata) begin n_err++; $display("FAIL rnd_mem_wdata c=%0d: observed %0h expected %0h", c, mem_wdata, e_wdata); end
            n_vec++; if (rd_gnt !== e_gnt)      begin n_err++; $display("FAIL rnd_rd_gnt c=%0d: observed %b expected %b", c, rd_gnt, e_gnt); end
            n_vec++; if (rd_valid !== e_rv)     begin n_err++; $display("FAIL rnd_rd_valid c=%0d: observed %b expected %b", c, rd_valid, e_rv); end
            n_vec++; if (rd_data !== e_rd)      begin n_err++; $display("FAIL rnd_rd_data c=%0d: observed %0h expected %0h", c, rd_data, e_rd); end
            n_vec++; if (disp_valid !== e_dv)   begin n_err++; $display("FAIL rnd_disp_valid c=%0d: observed %b expected %b", c, disp_valid, e_dv); end
            n_vec++; if (disp_data !== e_dd)    begin n_err++; $display("FAIL rnd_disp_data c=%0d: observed %0h expected %0h", c, disp_data, e_dd); end
            n_vec++; if (fifo_level !== 4'(m_q.size())) begin n_err++; $display("FAIL rnd_level c=%0d: observed %0d expected %0d", c, fifo_level, m_q.size()); end
            n_vec++; if (wr_ready !== (m_q.size() < 8)) begin n_err++; $display("FAIL rnd_wr_ready c=%0d: observed %b expected %b", c, wr_ready, m_q.size() < 8); end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        for (int a = 0; a < 256; a++) mmem[a] = init_val(a);
        m_rdata = '0;
        model_reset();
        @(negedge clk_25mhz);
        test_reset();
        test_write_order();
        test_disp_burst();
        test_round_robin();
        test_backpressure();
        test_push_pop();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
